// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR MAC sequencer.
// Holds the FSM state enum, address width and sizing helpers.
package fir_pkg;

  localparam int ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    ROUND,
    OUT
  } fir_state_e;

  function automatic int acc_width(
    input int dw,
    input int cw,
    input int taps
  );
    return dw + cw + $clog2(taps);
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample ring for the FIR engine: synchronous write at the write
// pointer, combinational read addressed by tap offset from newest.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int TAPS   = 64,
  parameter int DATA_W = 24
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  input  logic [cnt_width(TAPS)-1:0]    rd_off_i,
  output logic [DATA_W-1:0]             rd_data_o
);

  localparam int PTR_W = cnt_width(TAPS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(TAPS - 1);

  logic [DATA_W-1:0] ring_q [TAPS];
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  newest_q;
  logic [PTR_W-1:0]  rd_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) begin
        ring_q[i] <= '0;
      end
      wptr_q   <= '0;
      newest_q <= LAST;
    end else if (wr_en_i) begin
      ring_q[wptr_q] <= wr_data_i;
      newest_q       <= wptr_q;
      wptr_q         <= (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
    end
  end

  // (newest - off) mod TAPS; for power-of-two TAPS the add wraps to 0
  always_comb begin
    if (newest_q >= rd_off_i) begin
      rd_idx = newest_q - rd_off_i;
    end else begin
      rd_idx = PTR_W'(TAPS) + newest_q - rd_off_i;
    end
  end

  assign rd_data_o = ring_q[rd_idx];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Single-channel FIR: one sample in, TAPS coefficient reads, one out.
// Build option FIR_SAT_EN: saturate the rounded result instead of wrapping.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS      = 64,
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 16,
  parameter int COEF_BASE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] asi_data,
  input  logic              asi_valid,
  output logic              asi_ready,
  output logic [DATA_W-1:0] aso_data,
  output logic              aso_valid,
  input  logic              aso_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata
);

  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int K_W    = cnt_width(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] RND_C =
    {{(ACC_W-1){1'b0}}, 1'b1} << (COEF_W - 2);

  fir_state_e state_q, state_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [K_W-1:0]           tap_q;
  logic                     rd_vld_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        dout_q, dout_d;

  logic                     accept;
  logic [DATA_W-1:0]        x_raw;
  logic signed [DATA_W-1:0] x_tap;
  logic signed [COEF_W-1:0] coef;
  logic signed [PROD_W-1:0] x_ext, c_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [DATA_W-1:0]        narrow;
  logic                     unused_rd;

  assign accept = (state_q == IDLE) && asi_valid;

  fir_delay_line #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W)
  ) u_dly (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (accept),
    .wr_data_i (asi_data),
    .rd_off_i  (tap_q),
    .rd_data_o (x_raw)
  );

  assign x_tap     = x_raw;
  assign coef      = avm_readdata[COEF_W-1:0];
  assign unused_rd = ^avm_readdata[31:COEF_W];

  assign x_ext    = {{COEF_W{x_tap[DATA_W-1]}}, x_tap};
  assign c_ext    = {{DATA_W{coef[COEF_W-1]}}, coef};
  assign prod     = x_ext * c_ext;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

`ifdef FIR_SAT_EN
  logic signed [ACC_W-1:0] shifted;
  logic [ACC_W-DATA_W:0]   hi;

  assign shifted = (acc_q + RND_C) >>> (COEF_W - 1);
  assign hi      = shifted[ACC_W-1:DATA_W-1];

  always_comb begin
    if (&hi || ~|hi) begin
      narrow = shifted[DATA_W-1:0];
    end else if (hi[ACC_W-DATA_W]) begin
      narrow = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      narrow = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign narrow = DATA_W'((acc_q + RND_C) >>> (COEF_W - 1));
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (asi_valid) begin
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: state_d = ROUND;
      ROUND: begin
        dout_d  = narrow;
        state_d = OUT;
      end
      OUT: begin
        if (aso_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // coefficient read issued last cycle lands now
    if (rd_vld_q) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      tap_q    <= '0;
      rd_vld_q <= 1'b0;
      acc_q    <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      tap_q    <= k_q;
      rd_vld_q <= (state_q == MAC);
      acc_q    <= acc_d;
      dout_q   <= dout_d;
    end
  end

  assign asi_ready      = (state_q == IDLE);
  assign aso_valid      = (state_q == OUT);
  assign aso_data       = dout_q;
  assign avm_chipselect = (state_q == MAC);
  assign avm_address    = (state_q == MAC)
                        ? ADDR_W'(COEF_BASE) + ADDR_W'(k_q)
                        : ADDR_W'(COEF_BASE);
  assign avm_write      = 1'b0;
  assign avm_byteenable = 4'hF;

endmodule
